melody_seq_ctrl: RTL and testbench
==================================

MELODY_SEQ_CTRL -- requirements
Module: melody_seq_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 5000000, meaning clock cycles per played note.
REQ-002 The block SHALL have parameter GAP_DIV, default 1250000, meaning clock cycles of silence after each played note.
REQ-003 clk  input  1  system clock, all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 key_valid  input  1  one-cycle pulse: a user note is entered.
REQ-006 key_note  input  4  note code accompanying key_valid (0 = rest).
REQ-007 play_req  input  1  one-cycle pulse: request playback of the stored melody.
REQ-008 clear_req  input  1  one-cycle pulse: erase the stored melody.
REQ-009 answer_out  output  32  packed melody, note i in bits [4i+3:4i], i = 0..7.
REQ-010 answer_we  output  1  one-cycle write strobe qualifying answer_out toward the answer store.
REQ-011 note_count  output  4  number of stored notes, 0..8.
REQ-012 piezo_note  output  4  note currently driven to the piezo, 0 = silence.
REQ-013 busy  output  1  high while in PLAY_NOTE or PLAY_GAP.
REQ-014 full  output  1  high when note_count = 8.
REQ-015 done  output  1  one-cycle pulse at the end of a playback request.

Function
REQ-016 The block SHALL implement states IDLE, FEEDBACK, PLAY_NOTE, PLAY_GAP, with a single cycle counter cleared on every state entry.
REQ-017 IDLE/FEEDBACK with key_valid and note_count < 8 SHALL write key_note into slot note_count, increment note_count, and assert answer_we the next cycle with the updated answer_out.
REQ-018 key_valid while full SHALL be dropped: no slot change, no answer_we, no feedback.
REQ-019 An accepted key SHALL enter FEEDBACK: piezo_note = key_note for TICK_DIV cycles, then IDLE with piezo_note = 0; a new accepted key in FEEDBACK restarts FEEDBACK with the new note.
REQ-020 play_req in IDLE/FEEDBACK with note_count > 0 SHALL enter PLAY_NOTE with index 0 on the next edge; busy rises that same edge.
REQ-021 PLAY_NOTE SHALL drive piezo_note = slot[index] for exactly TICK_DIV cycles, then enter PLAY_GAP.
REQ-022 PLAY_GAP SHALL drive piezo_note = 0 for exactly GAP_DIV cycles, then enter PLAY_NOTE with index+1, or IDLE if index = note_count-1.
REQ-023 The transition PLAY_GAP -> IDLE SHALL pulse done for one cycle and drop busy.
REQ-024 play_req with note_count = 0 SHALL pulse done on the next cycle and remain in IDLE.
REQ-025 play_req and key_valid in the same cycle SHALL give priority to play_req; the key is dropped.
REQ-026 key_valid and play_req during PLAY_NOTE/PLAY_GAP SHALL be ignored.
REQ-027 clear_req SHALL override every other input in any state: next edge enters IDLE, answer_out = 0, note_count = 0, piezo_note = 0, busy = 0, answer_we pulsed once, done not pulsed.
REQ-028 Slots at index >= note_count SHALL always read 0 in answer_out.
REQ-029 answer_we SHALL never be high for two consecutive cycles from a single event.

Reset
REQ-030 reset SHALL asynchronously force IDLE, counter 0, index 0, answer_out = 0, note_count = 0, piezo_note = 0, answer_we = 0, busy = 0, full = 0, done = 0.
REQ-031 reset asserted mid-playback SHALL abort immediately with no done pulse.

Verification (TICK_DIV = 4, GAP_DIV = 2)
REQ-032 Keys 3,5,7 -> answer_out = 0x00000753, note_count = 3, three answer_we pulses; piezo_note = 3 for 4 cycles after the first key.
REQ-033 Then play_req -> piezo_note sequence 3x4, 0x2, 5x4, 0x2, 7x4, 0x2; busy high for 18 cycles; done pulses once at the end.
REQ-034 Nine keys 1..9 -> note_count = 8, full = 1, answer_out = 0x87654321; the ninth key produces no answer_we.
REQ-035 clear_req during the second PLAY_NOTE -> next cycle piezo_note = 0, busy = 0, note_count = 0, answer_out = 0, one answer_we, no done.
REQ-036 play_req with empty store -> done pulse on the next cycle, busy stays 0; simultaneous play_req + key_valid with 2 stored notes -> playback of 2 notes, note_count stays 2.
REQ-037 reset pulsed in PLAY_GAP -> all outputs at reset values in the same cycle; no done pulse afterwards.

Source files
------------

// File: rtl/melody_seq_ctrl.sv
// Melody sequencer: records up to eight 4-bit notes with audible key feedback,
// plays the stored melody note/gap by note/gap, and mirrors it to an answer store.
module melody_seq_ctrl #(
   parameter int unsigned TICK_DIV = 5000000,
   parameter int unsigned GAP_DIV  = 1250000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        key_valid,
   input  logic [3:0]  key_note,
   input  logic        play_req,
   input  logic        clear_req,
   output logic [31:0] answer_out,
   output logic        answer_we,
   output logic [3:0]  note_count,
   output logic [3:0]  piezo_note,
   output logic        busy,
   output logic        full,
   output logic        done
);

   localparam int unsigned CNT_MAX = (TICK_DIV > GAP_DIV) ? TICK_DIV : GAP_DIV;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      FEEDBACK,
      PLAY_NOTE,
      PLAY_GAP
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       idx;
   logic [2:0]       idx_nxt;
   logic [2:0]       last_idx;
   logic [3:0]       slot_next;

   assign full      = (note_count == 4'd8);
   assign idx_nxt   = idx + 3'd1;
   assign last_idx  = 3'(note_count - 4'd1);
   assign slot_next = answer_out[{idx_nxt, 2'b00} +: 4];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         answer_out <= '0;
         note_count <= '0;
         piezo_note <= '0;
         answer_we  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         answer_we <= 1'b0;
         done      <= 1'b0;
         if (clear_req) begin
            // clear wins over everything and is itself a store update, so it strobes answer_we
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            answer_out <= '0;
            note_count <= '0;
            piezo_note <= '0;
            busy       <= 1'b0;
            answer_we  <= 1'b1;
         end else begin
            case (state)
               IDLE, FEEDBACK: begin
                  if (play_req) begin
                     if (note_count != 4'd0) begin
                        state      <= PLAY_NOTE;
                        cnt        <= '0;
                        idx        <= '0;
                        piezo_note <= answer_out[3:0];
                        busy       <= 1'b1;
                     end else begin
                        done <= 1'b1;
                     end
                  end else if (key_valid && !full) begin
                     answer_out[{note_count[2:0], 2'b00} +: 4] <= key_note;
                     note_count <= note_count + 4'd1;
                     answer_we  <= 1'b1;
                     state      <= FEEDBACK;
                     cnt        <= '0;
                     piezo_note <= key_note;
                  end else if (state == FEEDBACK) begin
                     if (cnt == TICK_LAST) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        piezo_note <= '0;
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end
               end
               PLAY_NOTE: begin
                  if (cnt == TICK_LAST) begin
                     state      <= PLAY_GAP;
                     cnt        <= '0;
                     piezo_note <= '0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               PLAY_GAP: begin
                  if (cnt == GAP_LAST) begin
                     cnt <= '0;
                     if (idx == last_idx) begin
                        state <= IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        state      <= PLAY_NOTE;
                        idx        <= idx_nxt;
                        piezo_note <= slot_next;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_melody_seq_ctrl.sv
// Bench for melody_seq_ctrl: directed scenarios then random traffic, checked every
// cycle against a schedule-queue model of the stored melody and the piezo output.
module tb_melody_seq_ctrl;
   localparam int unsigned TICK = 4;
   localparam int unsigned GAP  = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        key_valid;
   logic [3:0]  key_note;
   logic        play_req;
   logic        clear_req;
   logic [31:0] answer_out;
   logic        answer_we;
   logic [3:0]  note_count;
   logic [3:0]  piezo_note;
   logic        busy;
   logic        full;
   logic        done;

   melody_seq_ctrl #(.TICK_DIV(TICK), .GAP_DIV(GAP)) dut (
      .clk(clk), .reset(reset), .key_valid(key_valid), .key_note(key_note),
      .play_req(play_req), .clear_req(clear_req), .answer_out(answer_out),
      .answer_we(answer_we), .note_count(note_count), .piezo_note(piezo_note),
      .busy(busy), .full(full), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int busy_seen, done_seen, we_seen;

   // model: stored notes plus a queue of piezo values for upcoming cycles
   int unsigned m_notes[$];
   logic [3:0]  m_sched[$];
   int          m_mode;   // 0 silent, 1 key feedback, 2 playback
   logic        m_we, m_done;

   function automatic logic [31:0] m_pack();
      logic [31:0] p = '0;
      foreach (m_notes[i]) p[i*4 +: 4] = 4'(m_notes[i]);
      return p;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [3:0] ep;
      ep = (m_sched.size() > 0) ? m_sched[0] : 4'd0;
      chk("answer_out", answer_out, m_pack());
      chk("note_count", 32'(note_count), 32'(m_notes.size()));
      chk("piezo_note", 32'(piezo_note), 32'(ep));
      chk("busy", 32'(busy), 32'(m_mode == 2));
      chk("full", 32'(full), 32'(m_notes.size() == 8));
      chk("answer_we", 32'(answer_we), 32'(m_we));
      chk("done", 32'(done), 32'(m_done));
   endtask

   task automatic model_reset();
      m_notes.delete();
      m_sched.delete();
      m_mode = 0;
      m_we   = 1'b0;
      m_done = 1'b0;
   endtask

   task automatic model_step(input logic clr, input logic play, input logic kv, input logic [3:0] kn);
      m_we   = 1'b0;
      m_done = 1'b0;
      if (clr) begin
         m_notes.delete();
         m_sched.delete();
         m_mode = 0;
         m_we   = 1'b1;
      end else if (m_mode == 2) begin
         void'(m_sched.pop_front());
         if (m_sched.size() == 0) begin
            m_mode = 0;
            m_done = 1'b1;
         end
      end else if (play) begin
         if (m_notes.size() > 0) begin
            m_sched.delete();
            foreach (m_notes[i]) begin
               repeat (TICK) m_sched.push_back(4'(m_notes[i]));
               repeat (GAP) m_sched.push_back(4'd0);
            end
            m_mode = 2;
         end else begin
            m_done = 1'b1;
         end
      end else if (kv && m_notes.size() < 8) begin
         m_notes.push_back(int'(kn));
         m_we = 1'b1;
         m_sched.delete();
         repeat (TICK) m_sched.push_back(kn);
         m_mode = 1;
      end else if (m_mode == 1) begin
         void'(m_sched.pop_front());
         if (m_sched.size() == 0) m_mode = 0;
      end
   endtask

   task automatic cycle(input logic clr, input logic play, input logic kv, input logic [3:0] kn);
      @(negedge clk);
      clear_req = clr;
      play_req  = play;
      key_valid = kv;
      key_note  = kn;
      @(posedge clk);
      model_step(clr, play, kv, kn);
      #1;
      clear_req = 1'b0;
      play_req  = 1'b0;
      key_valid = 1'b0;
      key_note  = 4'd0;
      check_all();
      busy_seen += int'(busy);
      done_seen += int'(done);
      we_seen   += int'(answer_we);
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 1'b0, 1'b0, 4'd0);
   endtask

   task automatic zero_counts();
      busy_seen = 0;
      done_seen = 0;
      we_seen   = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; clear_req = 1'b0; play_req = 1'b0; key_valid = 1'b0; key_note = 4'd0;
      zero_counts();
      #12;
      model_reset();
      check_all();
      @(negedge clk);
      reset = 1'b0;

      // three keys with full feedback windows
      zero_counts();
      cycle(1'b0, 1'b0, 1'b1, 4'd3);
      idle(5);
      cycle(1'b0, 1'b0, 1'b1, 4'd5);
      idle(5);
      cycle(1'b0, 1'b0, 1'b1, 4'd7);
      idle(5);
      chk("keys_answer", answer_out, 32'h0000_0753);
      chk("keys_count", 32'(note_count), 32'd3);
      chk("keys_we_pulses", 32'(we_seen), 32'd3);

      // full playback
      zero_counts();
      cycle(1'b0, 1'b1, 1'b0, 4'd0);
      idle(19);
      chk("play_busy_cycles", 32'(busy_seen), 32'd18);
      chk("play_done_pulses", 32'(done_seen), 32'd1);

      // fill past capacity
      cycle(1'b1, 1'b0, 1'b0, 4'd0);
      zero_counts();
      for (int i = 1; i <= 9; i++) cycle(1'b0, 1'b0, 1'b1, 4'(i));
      idle(5);
      chk("fill_answer", answer_out, 32'h8765_4321);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_we_pulses", 32'(we_seen), 32'd8);

      // clear during the second played note
      cycle(1'b0, 1'b1, 1'b0, 4'd0);
      idle(7);
      chk("second_note", 32'(piezo_note), 32'd2);
      zero_counts();
      cycle(1'b1, 1'b0, 1'b0, 4'd0);
      idle(4);
      chk("clr_we_pulses", 32'(we_seen), 32'd1);
      chk("clr_no_done", 32'(done_seen), 32'd0);
      chk("clr_busy", 32'(busy_seen), 32'd0);

      // empty playback, then play beating a simultaneous key
      zero_counts();
      cycle(1'b0, 1'b1, 1'b0, 4'd0);
      chk("empty_done", 32'(done), 32'd1);
      chk("empty_busy", 32'(busy), 32'd0);
      cycle(1'b0, 1'b0, 1'b1, 4'd4);
      idle(5);
      cycle(1'b0, 1'b0, 1'b1, 4'd9);
      idle(5);
      zero_counts();
      cycle(1'b0, 1'b1, 1'b1, 4'd6);
      idle(13);
      chk("prio_busy_cycles", 32'(busy_seen), 32'd12);
      chk("prio_done_pulses", 32'(done_seen), 32'd1);
      chk("prio_count", 32'(note_count), 32'd2);
      chk("prio_we_pulses", 32'(we_seen), 32'd0);

      // asynchronous reset in the first gap
      cycle(1'b0, 1'b1, 1'b0, 4'd0);
      idle(4);
      chk("in_gap_busy", 32'(busy), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      reset = 1'b0;
      zero_counts();
      idle(10);
      chk("rst_no_done", 32'(done_seen), 32'd0);

      // random traffic
      repeat (3000) begin
         int unsigned r;
         r = $urandom_range(0, 99);
         cycle(r < 2, (r >= 2) && (r < 8), $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
